// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 instruction codes, status codes and fetch helpers
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [63:0] LEN_OPCODE = 64'd1;
    localparam logic [63:0] LEN_REGIDS = 64'd1;
    localparam logic [63:0] LEN_VALC   = 64'd8;

    // Only rrmovq/cmovXX and jXX have 7 variants; OPq has 4; everything else has one.
    function automatic logic ifun_ok(input logic [3:0] icode, input logic [3:0] ifun);
        case (icode)
            I_RRMOVQ, I_JXX: return ifun <= 4'd6;
            I_OPQ:           return ifun <= 4'd3;
            default:         return ifun == 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - splits the 10-byte instruction word into fields and computes valP
import y86_pkg::*;

module fetch_align (
    input  logic [79:0] imem_data,
    input  logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc,
    output logic [63:0] valp,
    output logic        need_regids,
    output logic        need_valc,
    output logic        valid
);

    always_comb begin
        icode = imem_data[7:4];
        ifun  = imem_data[3:0];

        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
            default:                need_regids = 1'b0;
        endcase

        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_JXX, I_CALL: need_valc = 1'b1;
            default:       need_valc = 1'b0;
        endcase

        // Raw nibbles/bytes; the consumer gates them with the need flags.
        ra   = imem_data[15:12];
        rb   = imem_data[11:8];
        valc = need_regids ? imem_data[79:16] : imem_data[71:8];

        valp = pc + LEN_OPCODE
                  + (need_regids ? LEN_REGIDS : 64'd0)
                  + (need_valc   ? LEN_VALC   : 64'd0);

        valid = (icode <= I_POPQ) && ifun_ok(icode, ifun);
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Y86-64 fetch stage: PC select, predicted-PC register, halt latch
import y86_pkg::*;

module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_stall,
    input  logic [3:0]       m_icode,
    input  logic             m_cnd,
    input  logic [63:0]      m_valA,
    input  logic [3:0]       w_icode,
    input  logic [63:0]      w_valM,
    output logic [63:0]      imem_addr,
    input  logic [79:0]      imem_data,
    input  logic             imem_error,
    output logic [2:0]       stat_f,
    output logic [3:0]       icode_f,
    output logic [3:0]       ifun_f,
    output logic [3:0]       rA_f,
    output logic [3:0]       rB_f,
    output logic [63:0]      valc_f,
    output logic [63:0]      valp_f,
    output logic [63:0]      pred_pc,
    output logic [CNT_W-1:0] fetch_count
);

    logic        halted;
    logic        mispredict;
    logic        ret_redirect;
    logic        redirect;
    logic [63:0] pc;
    logic [3:0]  a_icode;
    logic [3:0]  a_ifun;
    logic [3:0]  a_ra;
    logic [3:0]  a_rb;
    logic [63:0] a_valc;
    logic [63:0] a_valp;
    logic        a_need_regids;
    logic        a_need_valc;
    logic        a_valid;
    logic [2:0]  raw_stat;
    logic [63:0] prediction;
    logic        bubble;
    logic        load;
    logic        halt_set;

    always_comb begin
        mispredict   = (m_icode == I_JXX) && !m_cnd;
        ret_redirect = (w_icode == I_RET);
        redirect     = mispredict || ret_redirect;
        if (mispredict)
            pc = m_valA;
        else if (ret_redirect)
            pc = w_valM;
        else
            pc = pred_pc;
    end

    fetch_align u_align (
        .imem_data   (imem_data),
        .pc          (pc),
        .icode       (a_icode),
        .ifun        (a_ifun),
        .ra          (a_ra),
        .rb          (a_rb),
        .valc        (a_valc),
        .valp        (a_valp),
        .need_regids (a_need_regids),
        .need_valc   (a_need_valc),
        .valid       (a_valid)
    );

    always_comb begin
        if (imem_error)
            raw_stat = STAT_ADR;
        else if (!a_valid)
            raw_stat = STAT_INS;
        else if (a_icode == I_HALT)
            raw_stat = STAT_HLT;
        else
            raw_stat = STAT_AOK;

        prediction = (a_icode == I_JXX || a_icode == I_CALL) ? a_valc : a_valp;

        // A redirect always wins: it reloads the PC even when stalled or halted.
        load     = redirect || (!f_stall && !halted);
        halt_set = (raw_stat != STAT_AOK) && !f_stall && !redirect && !halted;
        bubble   = !rst_n || (halted && !redirect);
    end

    always_comb begin
        imem_addr = rst_n ? pc : RESET_PC;
        if (bubble) begin
            stat_f  = STAT_AOK;
            icode_f = I_NOP;
            ifun_f  = 4'h0;
            rA_f    = RNONE;
            rB_f    = RNONE;
            valc_f  = 64'h0;
            valp_f  = 64'h0;
        end else begin
            stat_f  = raw_stat;
            icode_f = a_icode;
            ifun_f  = a_ifun;
            rA_f    = a_need_regids ? a_ra : RNONE;
            rB_f    = a_need_regids ? a_rb : RNONE;
            valc_f  = a_need_valc ? a_valc : 64'h0;
            valp_f  = a_valp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc     <= RESET_PC;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (load)
                pred_pc <= prediction;
            if (redirect)
                halted <= 1'b0;
            else if (halt_set)
                halted <= 1'b1;
            if (load && raw_stat == STAT_AOK)
                fetch_count <= fetch_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        f_stall;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_valA;
    logic [3:0]  w_icode;
    logic [63:0] w_valM;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;
    logic [2:0]  stat_f;
    logic [3:0]  icode_f;
    logic [3:0]  ifun_f;
    logic [3:0]  rA_f;
    logic [3:0]  rB_f;
    logic [63:0] valc_f;
    logic [63:0] valp_f;
    logic [63:0] pred_pc;
    logic [31:0] fetch_count;

    int n_chk;
    int n_fail;
    int exp_cnt;

    fetch_stage #(.RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_stall     (f_stall),
        .m_icode     (m_icode),
        .m_cnd       (m_cnd),
        .m_valA      (m_valA),
        .w_icode     (w_icode),
        .w_valM      (w_valM),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_error  (imem_error),
        .stat_f      (stat_f),
        .icode_f     (icode_f),
        .ifun_f      (ifun_f),
        .rA_f        (rA_f),
        .rB_f        (rB_f),
        .valc_f      (valc_f),
        .valp_f      (valp_f),
        .pred_pc     (pred_pc),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [63:0] c;
        bit          rf;
        bit          err;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] pred;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] build(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [63:0] c, input bit rf);
        return rf ? {c, b1, b0} : {8'h00, c, b0};
    endfunction

    initial begin
        n_chk = 0;
        n_fail = 0;
        vecs[0]  = '{64'h0,   8'h30, 8'hF2, 64'h10,   1, 0, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h10,   64'hA,   64'hA};
        vecs[1]  = '{64'h20,  8'h70, 8'h00, 64'h40,   0, 0, 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40,   64'h29,  64'h40};
        vecs[2]  = '{64'h100, 8'h60, 8'h12, 64'hDEAD, 1, 0, 3'd1, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0,    64'h102, 64'h102};
        vecs[3]  = '{64'h200, 8'h80, 8'h00, 64'h1234, 0, 0, 3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h1234, 64'h209, 64'h1234};
        vecs[4]  = '{64'h300, 8'h90, 8'h00, 64'h0,    0, 0, 3'd1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0,    64'h301, 64'h301};
        vecs[5]  = '{64'h400, 8'h00, 8'h00, 64'h0,    0, 0, 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,    64'h401, 64'h401};
        vecs[6]  = '{64'h500, 8'h10, 8'h00, 64'h0,    0, 0, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,    64'h501, 64'h501};
        vecs[7]  = '{64'h600, 8'h26, 8'h34, 64'h0,    1, 0, 3'd1, 4'h2, 4'h6, 4'h3, 4'h4, 64'h0,    64'h602, 64'h602};
        vecs[8]  = '{64'h700, 8'h27, 8'h34, 64'h0,    1, 0, 3'd4, 4'h2, 4'h7, 4'h3, 4'h4, 64'h0,    64'h702, 64'h702};
        vecs[9]  = '{64'h800, 8'h64, 8'h12, 64'h0,    1, 0, 3'd4, 4'h6, 4'h4, 4'h1, 4'h2, 64'h0,    64'h802, 64'h802};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFF8, 8'h30, 8'hF1, 64'h5, 1, 0, 3'd1, 4'h3, 4'h0, 4'hF, 4'h1, 64'h5, 64'h2, 64'h2};
        vecs[11] = '{64'h900, 8'hC0, 8'h00, 64'h0,    0, 0, 3'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0,    64'h901, 64'h901};
        vecs[12] = '{64'hA00, 8'h00, 8'h00, 64'h0,    0, 1, 3'd3, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,    64'hA01, 64'hA01};
        vecs[13] = '{64'hB00, 8'h50, 8'h45, 64'h18,   1, 0, 3'd1, 4'h5, 4'h0, 4'h4, 4'h5, 64'h18,   64'hB0A, 64'hB0A};
        vecs[14] = '{64'hC00, 8'hB0, 8'hAF, 64'h0,    1, 0, 3'd1, 4'hB, 4'h0, 4'hA, 4'hF, 64'h0,    64'hC02, 64'hC02};
        vecs[15] = '{64'hD00, 8'h11, 8'h00, 64'h0,    0, 0, 3'd4, 4'h1, 4'h1, 4'hF, 4'hF, 64'h0,    64'hD01, 64'hD01};

        // Reset: bubble and RESET_PC even with a ret redirect pending
        rst_n = 1'b0; f_stall = 1'b0; m_icode = 4'h0; m_cnd = 1'b0; m_valA = 64'h0;
        w_icode = 4'h9; w_valM = 64'h77; imem_data = build(8'h30, 8'hF2, 64'h10, 1); imem_error = 1'b0;
        tick(); tick();
        chk("rst imem_addr", imem_addr, 64'h0);
        chk("rst icode", {60'h0, icode_f}, 64'h1);
        chk("rst rA", {60'h0, rA_f}, 64'hF);
        chk("rst valc", valc_f, 64'h0);
        chk("rst valp", valp_f, 64'h0);
        chk("rst stat", {61'h0, stat_f}, 64'h1);
        chk("rst pred_pc", pred_pc, 64'h0);
        chk("rst count", {32'h0, fetch_count}, 64'h0);

        // irmovq at PC 0
        w_icode = 4'h0; rst_n = 1'b1; #1;
        chk("A icode", {60'h0, icode_f}, 64'h3);
        chk("A rA", {60'h0, rA_f}, 64'hF);
        chk("A rB", {60'h0, rB_f}, 64'h2);
        chk("A valc", valc_f, 64'h10);
        chk("A valp", valp_f, 64'hA);
        chk("A stat", {61'h0, stat_f}, 64'h1);
        tick();
        chk("A pred_pc", pred_pc, 64'hA);
        chk("A count", {32'h0, fetch_count}, 64'h1);

        // Stall three cycles on a nop
        f_stall = 1'b1; imem_data = build(8'h10, 8'h00, 64'h0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("B icode", {60'h0, icode_f}, 64'h1);
            chk("B valp", valp_f, 64'hB);
            tick();
            chk("B pred_pc", pred_pc, 64'hA);
            chk("B count", {32'h0, fetch_count}, 64'h1);
        end

        // ret redirect overrides the stall
        w_icode = 4'h9; w_valM = 64'h100; #1;
        chk("C imem_addr", imem_addr, 64'h100);
        tick();
        chk("C pred_pc", pred_pc, 64'h101);
        chk("C count", {32'h0, fetch_count}, 64'h2);
        f_stall = 1'b0;

        // jXX at 0x20 predicts taken, then a mispredict selects m_valA
        w_valM = 64'h20; imem_data = build(8'h70, 8'h00, 64'h40, 0); #1;
        chk("D imem_addr", imem_addr, 64'h20);
        tick();
        chk("D pred_pc", pred_pc, 64'h40);
        chk("D count", {32'h0, fetch_count}, 64'h3);
        w_icode = 4'h0; m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h29; #1;
        chk("D mispredict addr", imem_addr, 64'h29);
        m_cnd = 1'b1; #1;
        chk("D taken addr", imem_addr, 64'h40);
        m_icode = 4'h0; m_cnd = 1'b0;

        // Invalid opcode halts; bubble while halted; mispredict resumes
        imem_data = build(8'hC0, 8'h00, 64'h0, 0); #1;
        chk("E stat", {61'h0, stat_f}, 64'h4);
        tick();
        chk("E pred_pc", pred_pc, 64'h41);
        chk("E count", {32'h0, fetch_count}, 64'h3);
        chk("E bubble icode", {60'h0, icode_f}, 64'h1);
        chk("E bubble stat", {61'h0, stat_f}, 64'h1);
        chk("E bubble rA", {60'h0, rA_f}, 64'hF);
        chk("E bubble valp", valp_f, 64'h0);
        tick();
        chk("E held pred_pc", pred_pc, 64'h41);
        chk("E held count", {32'h0, fetch_count}, 64'h3);
        m_icode = 4'h7; m_valA = 64'h50; imem_data = build(8'h10, 8'h00, 64'h0, 0); #1;
        chk("E redirect addr", imem_addr, 64'h50);
        chk("E redirect valp", valp_f, 64'h51);
        tick();
        chk("E resume pred_pc", pred_pc, 64'h51);
        chk("E resume count", {32'h0, fetch_count}, 64'h4);
        m_icode = 4'h0; imem_data = build(8'h30, 8'hF2, 64'h10, 1); #1;
        chk("E resume icode", {60'h0, icode_f}, 64'h3);
        chk("E resume stat", {61'h0, stat_f}, 64'h1);

        // Decode table, each vector steered in via a ret redirect
        exp_cnt = 4;
        for (int i = 0; i < 16; i++) begin
            w_icode = 4'h9; w_valM = vecs[i].pc;
            imem_data = build(vecs[i].b0, vecs[i].b1, vecs[i].c, vecs[i].rf);
            imem_error = vecs[i].err;
            #1;
            chk($sformatf("v%0d addr", i), imem_addr, vecs[i].pc);
            chk($sformatf("v%0d stat", i), {61'h0, stat_f}, {61'h0, vecs[i].stat});
            chk($sformatf("v%0d icode", i), {60'h0, icode_f}, {60'h0, vecs[i].icode});
            chk($sformatf("v%0d ifun", i), {60'h0, ifun_f}, {60'h0, vecs[i].ifun});
            chk($sformatf("v%0d rA", i), {60'h0, rA_f}, {60'h0, vecs[i].ra});
            chk($sformatf("v%0d rB", i), {60'h0, rB_f}, {60'h0, vecs[i].rb});
            chk($sformatf("v%0d valc", i), valc_f, vecs[i].valc);
            chk($sformatf("v%0d valp", i), valp_f, vecs[i].valp);
            tick();
            if (vecs[i].stat == 3'd1) exp_cnt++;
            chk($sformatf("v%0d pred_pc", i), pred_pc, vecs[i].pred);
            chk($sformatf("v%0d count", i), {32'h0, fetch_count}, 64'(exp_cnt));
        end
        w_icode = 4'h0; imem_error = 1'b0;

        // imem_error with a halt byte, then asynchronous reset mid-cycle
        imem_data = build(8'h00, 8'h00, 64'h0, 0); imem_error = 1'b1; #1;
        chk("F stat", {61'h0, stat_f}, 64'h3);
        #2; rst_n = 1'b0; #1;
        chk("F pred_pc", pred_pc, 64'h0);
        chk("F count", {32'h0, fetch_count}, 64'h0);
        chk("F imem_addr", imem_addr, 64'h0);
        chk("F stat rst", {61'h0, stat_f}, 64'h1);
        chk("F icode rst", {60'h0, icode_f}, 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
